// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single RAM port (MFA/MFC handshake) between two requesters:
//   port 0 (CU fetch/load/store) and port 1 (preload/debug loader).
//   Ties are broken round-robin. r0_lock keeps port 1 out so port 0 can do
//   atomic back-to-back accesses. Each transfer runs MFA -> wait MFC -> ack
//   -> wait MFC release. A watchdog aborts transfers that never complete.
//
// Ports
//   Clk, Reset              clock, asynchronous active-low reset
//   rN_req/rd/size/addr/wdata  requester N transfer request and attributes
//   rN_ack/err/rdata        requester N completion pulse, abort flag, read data
//   r0_lock                 blocks new grants to port 1
//   MFA, MOP_SEL, m_size, m_addr, m_wdata   RAM start and latched attributes
//   MFC, m_rdata            RAM completion and read data
//   busy, grant             arbiter occupied, index of owning port
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              r0_req,
  input  logic              r0_rd,
  input  logic [1:0]        r0_size,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_ack,
  output logic              r0_err,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rd,
  input  logic [1:0]        r1_size,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_ack,
  output logic              r1_err,
  output logic [31:0]       r1_rdata,
  input  logic              r0_lock,
  output logic              MFA,
  output logic              MOP_SEL,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              MFC,
  input  logic [31:0]       m_rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT-1; a disabled watchdog keeps a 1-bit stub.
  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic            WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t              r_state,      w_state_nxt;
  logic                r_last_grant, w_last_nxt;
  logic                r_grant,      w_grant_nxt;
  logic                r_mfa,        w_mfa_nxt;
  logic                r_mop_sel,    w_mop_sel_nxt;
  logic [1:0]          r_m_size,     w_m_size_nxt;
  logic [ADDR_W-1:0]   r_m_addr,     w_m_addr_nxt;
  logic [31:0]         r_m_wdata,    w_m_wdata_nxt;
  logic                r_ack0,       w_ack0_nxt;
  logic                r_ack1,       w_ack1_nxt;
  logic                r_err0,       w_err0_nxt;
  logic                r_err1,       w_err1_nxt;
  logic [31:0]         r_rdata0,     w_rdata0_nxt;
  logic [31:0]         r_rdata1,     w_rdata1_nxt;
  logic [CNT_W-1:0]    r_wd_cnt,     w_wd_cnt_nxt;

  logic                w_req1_ok;
  logic                w_req_any;
  logic                w_win;
  logic                w_win_rd;
  logic [1:0]          w_win_size;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [31:0]         w_win_wdata;
  logic                w_wd_expire;

  // Arbitration: the lock masks port 1 entirely; a tie goes to the port that
  // did not own the previous transfer.
  assign w_req1_ok   = r1_req & ~r0_lock;
  assign w_req_any   = r0_req | w_req1_ok;
  assign w_win       = (r0_req & w_req1_ok) ? ~r_last_grant : w_req1_ok;
  assign w_win_rd    = w_win ? r1_rd    : r0_rd;
  assign w_win_size  = w_win ? r1_size  : r0_size;
  assign w_win_addr  = w_win ? r1_addr  : r0_addr;
  assign w_win_wdata = w_win ? r1_wdata : r0_wdata;

  assign w_wd_expire = WD_EN & (r_wd_cnt == WD_LAST);

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last_grant;
    w_grant_nxt   = r_grant;
    w_mfa_nxt     = r_mfa;
    w_mop_sel_nxt = r_mop_sel;
    w_m_size_nxt  = r_m_size;
    w_m_addr_nxt  = r_m_addr;
    w_m_wdata_nxt = r_m_wdata;
    w_rdata0_nxt  = r_rdata0;
    w_rdata1_nxt  = r_rdata1;
    w_wd_cnt_nxt  = r_wd_cnt;
    w_ack0_nxt    = 1'b0;
    w_ack1_nxt    = 1'b0;
    w_err0_nxt    = 1'b0;
    w_err1_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // MFC is deliberately not looked at here: a late MFC from an
        // abandoned cycle must not start or finish anything.
        if (w_req_any) begin
          w_grant_nxt   = w_win;
          w_mop_sel_nxt = w_win_rd;
          w_m_size_nxt  = w_win_size;
          w_m_addr_nxt  = w_win_addr;
          w_m_wdata_nxt = w_win_wdata;
          w_mfa_nxt     = 1'b1;
          w_wd_cnt_nxt  = '0;
          w_state_nxt   = S_BUSY;
        end else begin
          w_mfa_nxt     = 1'b0;
        end
      end

      S_BUSY: begin
        if (MFC) begin
          w_mfa_nxt   = 1'b0;
          w_last_nxt  = r_grant;
          w_state_nxt = S_RELEASE;
          if (r_grant) begin
            w_ack1_nxt = 1'b1;
            if (r_mop_sel) begin
              w_rdata1_nxt = m_rdata;
            end else begin
              w_rdata1_nxt = r_rdata1;
            end
          end else begin
            w_ack0_nxt = 1'b1;
            if (r_mop_sel) begin
              w_rdata0_nxt = m_rdata;
            end else begin
              w_rdata0_nxt = r_rdata0;
            end
          end
        end else if (w_wd_expire) begin
          // Abort: ack with err, read data is left as it was.
          w_mfa_nxt   = 1'b0;
          w_last_nxt  = r_grant;
          w_state_nxt = S_RELEASE;
          if (r_grant) begin
            w_ack1_nxt = 1'b1;
            w_err1_nxt = 1'b1;
          end else begin
            w_ack0_nxt = 1'b1;
            w_err0_nxt = 1'b1;
          end
        end else begin
          w_wd_cnt_nxt = r_wd_cnt + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        // Hold off the next grant until the RAM has dropped MFC.
        if (!MFC) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RELEASE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_mfa_nxt   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any RAM cycle in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_mfa        <= 1'b0;
      r_mop_sel    <= 1'b1;
      r_m_size     <= 2'd2;
      r_m_addr     <= '0;
      r_m_wdata    <= 32'h0000_0000;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= 32'h0000_0000;
      r_rdata1     <= 32'h0000_0000;
      r_wd_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_grant      <= w_grant_nxt;
      r_mfa        <= w_mfa_nxt;
      r_mop_sel    <= w_mop_sel_nxt;
      r_m_size     <= w_m_size_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_err0       <= w_err0_nxt;
      r_err1       <= w_err1_nxt;
      r_rdata0     <= w_rdata0_nxt;
      r_rdata1     <= w_rdata1_nxt;
      r_wd_cnt     <= w_wd_cnt_nxt;
    end
  end

  assign MFA      = r_mfa;
  assign MOP_SEL  = r_mop_sel;
  assign m_size   = r_m_size;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign r0_ack   = r_ack0;
  assign r1_ack   = r_ack1;
  assign r0_err   = r_err0;
  assign r1_err   = r_err1;
  assign r0_rdata = r_rdata0;
  assign r1_rdata = r_rdata1;
  assign grant    = r_grant;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a byte-wide big-endian RAM model answers
// the MFA/MFC handshake, a scoreboard queue holds the expected ack sequence
// (port, err, rdata), and a table of single transfers plus hand-written
// sequences cover ties, lock, watchdog abort and reset mid-transfer.
module tb_mem_port_arbiter;

  logic        Clk;
  logic        rst_n;
  logic        r0_req, r0_rd, r1_req, r1_rd, r0_lock;
  logic [1:0]  r0_size, r1_size;
  logic [7:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        MFA, MOP_SEL, MFC, busy, grant;
  logic [1:0]  m_size;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  mem_port_arbiter #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(rst_n),
    .r0_req(r0_req), .r0_rd(r0_rd), .r0_size(r0_size), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rd(r1_rd), .r1_size(r1_size), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .r0_lock(r0_lock),
    .MFA(MFA), .MOP_SEL(MOP_SEL), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .MFC(MFC), .m_rdata(m_rdata),
    .busy(busy), .grant(grant)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- RAM model ----------------
  logic [7:0] mem [256];
  bit         mfc_en    = 1'b1;
  bit         mfc_force = 1'b0;
  logic [7:0] ra1, ra2, ra3;

  assign MFC = mfc_force | (MFA & mfc_en);
  assign ra1 = m_addr + 8'd1;
  assign ra2 = m_addr + 8'd2;
  assign ra3 = m_addr + 8'd3;

  always_comb begin
    case (m_size)
      2'd0:    m_rdata = {24'h000000, mem[m_addr]};
      2'd1:    m_rdata = {16'h0000, mem[m_addr], mem[ra1]};
      default: m_rdata = {mem[m_addr], mem[ra1], mem[ra2], mem[ra3]};
    endcase
  end

  always @(posedge Clk) begin
    if (MFA && MFC && !MOP_SEL) begin
      case (m_size)
        2'd0: mem[m_addr] <= m_wdata[7:0];
        2'd1: begin
          mem[m_addr] <= m_wdata[15:8];
          mem[ra1]    <= m_wdata[7:0];
        end
        default: begin
          mem[m_addr] <= m_wdata[31:24];
          mem[ra1]    <= m_wdata[23:16];
          mem[ra2]    <= m_wdata[15:8];
          mem[ra3]    <= m_wdata[7:0];
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_rd [2];
  int          mfa_rise[$];
  logic        mfa_prev = 1'b0;

  always @(negedge Clk) begin
    mfa_prev <= MFA;
    if (MFA && !mfa_prev) mfa_rise.push_back(cyc);
  end

  always @(negedge Clk) begin
    if (rst_n && (r0_ack || r1_ack)) begin
      if (r0_ack && r1_ack) begin
        n_vec++; n_miss++;
        $display("FAIL dual_ack: got both acks, expected one (cycle %0d)", cyc);
      end else if (sb_q.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_ack: got ack on port %0d, expected none (cycle %0d)", r1_ack, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_port",  {31'd0, r1_ack}, {31'd0, e.port});
        check("ack_grant", {31'd0, grant},  {31'd0, e.port});
        check("ack_err",   {31'd0, (r1_ack ? r1_err : r0_err)}, {31'd0, e.err});
        check("ack_rdata", (r1_ack ? r1_rdata : r0_rdata), e.rdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit          port;
    bit          rd;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic set_port(input bit p, input bit rd, input logic [1:0] sz,
                          input logic [7:0] a, input logic [31:0] wd);
    if (p) begin
      r1_rd = rd; r1_size = sz; r1_addr = a; r1_wdata = wd;
    end else begin
      r0_rd = rd; r0_size = sz; r0_addr = a; r0_wdata = wd;
    end
  endtask

  task automatic push_exp(input bit p, input bit err, input logic [31:0] rd);
    exp_t e;
    e.port = p; e.err = err; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic wait_ack(input bit p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (p ? r1_ack : r0_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++; n_miss++;
      $display("FAIL ack_timeout: got no ack on port %0d, expected one within 100 cycles", p);
    end
  endtask

  task automatic do_xfer(input vec_t v);
    bit ok;
    int c0;
    @(negedge Clk);
    set_port(v.port, v.rd, v.size, v.addr, v.wdata);
    if (v.port) r1_req = 1'b1; else r0_req = 1'b1;
    c0 = cyc;
    push_exp(v.port, 1'b0, v.rd ? v.rdata : last_rd[v.port]);
    if (v.rd) last_rd[v.port] = v.rdata;
    @(negedge Clk);
    check("grant_mfa",   {31'd0, MFA},     32'd1);
    check("grant_port",  {31'd0, grant},   {31'd0, v.port});
    check("grant_mop",   {31'd0, MOP_SEL}, {31'd0, v.rd});
    check("grant_maddr", {24'd0, m_addr},  {24'd0, v.addr});
    if (v.size != 2'd3) check("grant_msize", {30'd0, m_size}, {30'd0, v.size});
    if (!v.rd) check("grant_mwdata", m_wdata, v.wdata);
    wait_ack(v.port, ok);
    if (ok) check("req_to_ack_edges", cyc - c0, 32'd2);
    if (v.port) r1_req = 1'b0; else r0_req = 1'b0;
  endtask

  initial begin
    bit ok;
    int n, n0, c3, c1, cg;
    bit got0, got1;

    tbl[0]  = '{1'b0, 1'b1, 2'd2, 8'h10, 32'h0,        32'h9C044012};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 8'h20, 32'hFFFFFFA5, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 2'd0, 8'h20, 32'h0,        32'h000000A5};
    tbl[3]  = '{1'b0, 1'b1, 2'd0, 8'h1F, 32'h0,        32'h00000011};
    tbl[4]  = '{1'b0, 1'b1, 2'd0, 8'h21, 32'h0,        32'h00000033};
    tbl[5]  = '{1'b1, 1'b1, 2'd1, 8'h12, 32'h0,        32'h00004012};
    tbl[6]  = '{1'b0, 1'b0, 2'd1, 8'h30, 32'h0000BEEF, 32'h0};
    tbl[7]  = '{1'b1, 1'b1, 2'd2, 8'h30, 32'h0,        32'hBEEF0000};
    tbl[8]  = '{1'b1, 1'b0, 2'd3, 8'h40, 32'h01234567, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 2'd2, 8'h40, 32'h0,        32'h01234567};
    tbl[10] = '{1'b1, 1'b1, 2'd3, 8'h40, 32'h0,        32'h01234567};

    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'h9C; mem[8'h11] <= 8'h04; mem[8'h12] <= 8'h40; mem[8'h13] <= 8'h12;
    mem[8'h1F] <= 8'h11; mem[8'h20] <= 8'h22; mem[8'h21] <= 8'h33;

    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    r0_req = 1'b0; r1_req = 1'b0; r0_lock = 1'b0;
    set_port(1'b0, 1'b0, 2'd0, 8'h00, 32'h0);
    set_port(1'b1, 1'b0, 2'd0, 8'h00, 32'h0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge Clk);

    // reset state
    check("rst_mfa",    {31'd0, MFA},     32'd0);
    check("rst_mopsel", {31'd0, MOP_SEL}, 32'd1);
    check("rst_msize",  {30'd0, m_size},  32'd2);
    check("rst_maddr",  {24'd0, m_addr},  32'd0);
    check("rst_mwdata", m_wdata,          32'd0);
    check("rst_acks",   {30'd0, r0_ack, r1_ack}, 32'd0);
    check("rst_errs",   {30'd0, r0_err, r1_err}, 32'd0);
    check("rst_rdata0", r0_rdata, 32'd0);
    check("rst_rdata1", r1_rdata, 32'd0);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_grant",  {31'd0, grant}, 32'd0);
    rst_n = 1'b1;

    // single transfers
    for (int i = 0; i < 11; i++) do_xfer(tbl[i]);

    // tie and fairness: last owner was port 1, so 0,1,0,1
    @(negedge Clk);
    set_port(1'b0, 1'b1, 2'd2, 8'h10, 32'h0);
    set_port(1'b1, 1'b1, 2'd2, 8'h40, 32'h0);
    push_exp(1'b0, 1'b0, 32'h9C044012); push_exp(1'b1, 1'b0, 32'h01234567);
    push_exp(1'b0, 1'b0, 32'h9C044012); push_exp(1'b1, 1'b0, 32'h01234567);
    last_rd[0] = 32'h9C044012; last_rd[1] = 32'h01234567;
    mfa_rise.delete();
    r0_req = 1'b1; r1_req = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge Clk);
      if (r0_ack || r1_ack) n++;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("fair_ack_count", n, 32'd4);
    check("fair_mfa_rises", mfa_rise.size(), 32'd4);
    if (mfa_rise.size() == 4) begin
      for (int i = 1; i < 4; i++) check("fair_mfa_spacing", mfa_rise[i] - mfa_rise[i-1], 32'd3);
    end

    // lock: three port-0 transfers while port 1 waits, then port 1
    @(negedge Clk);
    set_port(1'b0, 1'b1, 2'd0, 8'h20, 32'h0);
    set_port(1'b1, 1'b1, 2'd1, 8'h12, 32'h0);
    push_exp(1'b0, 1'b0, 32'h000000A5); push_exp(1'b0, 1'b0, 32'h000000A5);
    push_exp(1'b0, 1'b0, 32'h000000A5); push_exp(1'b1, 1'b0, 32'h00004012);
    last_rd[0] = 32'h000000A5; last_rd[1] = 32'h00004012;
    r0_lock = 1'b1; r0_req = 1'b1; r1_req = 1'b1;
    n0 = 0; got1 = 1'b0; c3 = 0; c1 = 0;
    for (int i = 0; i < 200 && !got1; i++) begin
      @(negedge Clk);
      if (r1_ack) begin
        got1 = 1'b1; c1 = cyc;
      end
      if (r0_ack) begin
        n0++;
        if (n0 == 3) begin
          r0_req = 1'b0; r0_lock = 1'b0; c3 = cyc;
        end
      end
    end
    r1_req = 1'b0; r0_req = 1'b0; r0_lock = 1'b0;
    check("lock_r0_count", n0, 32'd3);
    check("lock_r1_acked", {31'd0, got1}, 32'd1);
    check("lock_r1_delay", c1 - c3, 32'd3);

    // MFC while idle is ignored
    @(negedge Clk);
    mfc_force = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_mfc_busy", {31'd0, busy}, 32'd0);
    check("idle_mfc_mfa",  {31'd0, MFA},  32'd0);
    mfc_force = 1'b0;

    // watchdog: MFC never arrives, abort on the 16th edge after grant
    mfc_en = 1'b0;
    @(negedge Clk);
    set_port(1'b0, 1'b1, 2'd2, 8'h10, 32'h0);
    push_exp(1'b0, 1'b1, last_rd[0]);
    r0_req = 1'b1;
    @(negedge Clk);
    cg = cyc;
    check("wd_mfa_on", {31'd0, MFA}, 32'd1);
    set_port(1'b0, 1'b0, 2'd0, 8'hEE, 32'hDEADBEEF);
    wait_ack(1'b0, ok);
    if (ok) begin
      check("wd_ack_edge",   cyc - cg, 32'd16);
      check("wd_mfa_off",    {31'd0, MFA},     32'd0);
      check("wd_maddr_hold", {24'd0, m_addr},  32'h10);
      check("wd_mop_hold",   {31'd0, MOP_SEL}, 32'd1);
    end
    r0_req = 1'b0;

    // reset two cycles after grant; no ack, then port 0 wins the tie
    @(negedge Clk);
    set_port(1'b0, 1'b1, 2'd2, 8'h10, 32'h0);
    r0_req = 1'b1;
    @(negedge Clk);
    check("rbusy_mfa_on", {31'd0, MFA}, 32'd1);
    @(posedge Clk);
    @(posedge Clk);
    #1 rst_n = 1'b0;
    #1;
    check("rbusy_mfa",    {31'd0, MFA},  32'd0);
    check("rbusy_busy",   {31'd0, busy}, 32'd0);
    check("rbusy_rdata0", r0_rdata,      32'd0);
    check("rbusy_mopsel", {31'd0, MOP_SEL}, 32'd1);
    r0_req = 1'b0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    repeat (2) @(negedge Clk);
    rst_n = 1'b1;
    mfc_en = 1'b1;
    @(negedge Clk);
    set_port(1'b0, 1'b1, 2'd0, 8'h20, 32'h0);
    set_port(1'b1, 1'b1, 2'd0, 8'h1F, 32'h0);
    push_exp(1'b0, 1'b0, 32'h000000A5); push_exp(1'b1, 1'b0, 32'h00000011);
    r0_req = 1'b1; r1_req = 1'b1;
    got0 = 1'b0; got1 = 1'b0;
    for (int i = 0; i < 100 && !(got0 && got1); i++) begin
      @(negedge Clk);
      if (r0_ack) begin got0 = 1'b1; r0_req = 1'b0; end
      if (r1_ack) begin got1 = 1'b1; r1_req = 1'b0; end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    check("rtie_both_acked", {30'd0, got0, got1}, 32'd3);

    repeat (3) @(negedge Clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
